seq_ram_writer: RTL
===================

Name: seq_ram_writer

Overview:
- Sequential writer for a single-port on-chip memory of 2**ADDR_WIDTH words.
- Accepts a valid/ready word stream and writes words to consecutive addresses from 0. Tracks the fill level and flags full.
- Exposes an asynchronous read port, so loaded contents can be fetched exactly like the asynchronous ROM blocks.
- Used to load lookup tables at run time instead of fixing them at synthesis.

Parameters:
- DATA_WIDTH, 8, width of each memory word.
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  rising-edge clock.
- n_reset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins/restarts a load at address 0.
- wr_valid  input  1  wr_data holds a word to write.
- wr_data  input  DATA_WIDTH  word to write.
- wr_ready  output  1  writer accepts a word this cycle.
- rd_addr  input  ADDR_WIDTH  asynchronous read address.
- rd_data  output  DATA_WIDTH  mem[rd_addr], combinational.
- count  output  ADDR_WIDTH+1  words written since last start (0..DEPTH).
- full  output  1  all DEPTH words written.
- busy  output  1  load in progress (state FILL).

Behaviour:
- Clock and reset: one clock, clk. Reset n_reset is asynchronous, active-low.
- Reset values:
  - state=IDLE, wr_ptr=0, count=0.
  - wr_ready=0, full=0, busy=0.
  - Memory array is not reset; contents are undefined until written.
  - rd_data follows memory contents even while in reset.
- States: IDLE, FILL, FULL.
  - IDLE: wr_ready=0. start -> FILL with wr_ptr=0, count=0.
  - FILL: wr_ready=1, busy=1.
    - Handshake: a transfer occurs on a rising clk edge when wr_valid && wr_ready.
    - On transfer: mem[wr_ptr]<=wr_data, wr_ptr<=wr_ptr+1, count<=count+1.
    - A transfer at wr_ptr==DEPTH-1 -> FULL.
    - wr_valid low: hold, no write.
  - FULL: wr_ready=0, full=1, count=DEPTH. wr_valid is ignored. start -> FILL with wr_ptr=0, count=0, full=0. Previous contents are retained until overwritten.
- start while in FILL restarts the load:
  - wr_ptr and count go to 0 on that edge.
  - A transfer presented in the same cycle is discarded, not written.
  - start has priority over a transfer.
- Latency:
  - A write is visible on rd_data from the edge that accepts it (zero cycles after the edge).
  - Before that edge, rd_data shows the old word, including when rd_addr equals the address being written.
- count and full are registered outputs and update on the accepting edge.
- wr_ptr is internal and is not exported.
- Reset asserted mid-load: immediate return to IDLE. Words already written stay in memory. count=0.

Optional Feature:
- Macro: SEQ_RAM_WRAP_EN.
- Defined (circular mode):
  - A transfer at wr_ptr==DEPTH-1 wraps wr_ptr to 0 and stays in FILL.
  - full becomes a sticky flag, set on the first wrap and cleared only by start or reset.
  - count saturates at DEPTH.
  - wr_ready stays 1 until start or reset.
  - State FULL is not reachable.
- Undefined: behaviour as above, with no wrap.

Test Plan:
1. Reset, then check outputs and idle handshake:
   - n_reset low -> wr_ready=0, full=0, busy=0, count=0.
   - wr_valid=1 in IDLE with wr_data=8'hFF for 3 cycles -> count stays 0 and no word is written.
2. Full load and readback:
   - start, then stream 8'hED,8'hB7,8'h18,8'hE7,8'hCC,8'h0F,8'hF0,8'hAA with wr_valid held high -> 8 consecutive transfers, then full=1, count=8, wr_ready=0.
   - rd_addr 0..7 -> rd_data equals the streamed sequence in order, e.g. addr 7=8'hAA, addr 0=8'hED.
3. Backpressure and gaps:
   - wr_valid toggled 1,0,1,0 with data 8'h11,8'h22,8'h33,8'h44 -> only 8'h11 and 8'h33 are written, at addresses 0 and 1; count=2.
4. Restart mid-load and same-cycle write:
   - After 3 words, pulse start together with wr_valid and 8'h99 -> count=0, 8'h99 is not written, address 0 keeps its old word.
   - Next transfer 8'h55 -> address 0 = 8'h55.
   - rd_addr=0 during the accepting cycle -> old value before the edge, 8'h55 after.
5. Reset mid-load:
   - Pull n_reset low asynchronously between edges after 4 words -> busy and count drop immediately.
   - Addresses 0..3 still read the written words.
6. With SEQ_RAM_WRAP_EN defined:
   - Stream 10 words 8'h01..8'h0A -> full=1 after the 8th, wr_ready stays 1, count=8.
   - Address 0 reads 8'h09, address 1 reads 8'h0A, address 2 reads 8'h03.

Source files
------------

// File: rtl/seq_ram_writer_if.sv
// Write-stream and asynchronous read-port bundle for seq_ram_writer.
// master: the producer and reader. slave: the writer block.
interface seq_ram_writer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_addr,
    input  wr_ready, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_addr,
    output wr_ready, rd_data
  );
endinterface

// File: rtl/seq_ram_writer.sv
// Sequential loader for a 2**ADDR_WIDTH-word RAM with an asynchronous read port.
// Optional macro SEQ_RAM_WRAP_EN: circular fill with a sticky full flag instead of stopping.
module seq_ram_writer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                start,
  seq_ram_writer_if.slave     bus,
  output logic [ADDR_WIDTH:0] count,
  output logic                full,
  output logic                busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FULL
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_en;
  logic                  last;

  // start in FILL wins over a same-cycle transfer
  assign wr_en = (state == S_FILL) && bus.wr_valid && !start;
  assign last  = (wr_ptr == ADDR_WIDTH'(DEPTH - 1));

  assign bus.rd_data = mem[bus.rd_addr];

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      count        <= '0;
      bus.wr_ready <= 1'b0;
      full         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FULL: begin
          if (start) begin
            state        <= S_FILL;
            wr_ptr       <= '0;
            count        <= '0;
            bus.wr_ready <= 1'b1;
            full         <= 1'b0;
            busy         <= 1'b1;
          end
        end
        S_FILL: begin
          if (start) begin
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
          end else if (bus.wr_valid) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
`ifdef SEQ_RAM_WRAP_EN
            if (count != CNT_W'(DEPTH)) begin
              count <= count + CNT_W'(1);
            end
            if (last) begin
              full <= 1'b1;
            end
`else
            count <= count + CNT_W'(1);
            if (last) begin
              state        <= S_FULL;
              bus.wr_ready <= 1'b0;
              busy         <= 1'b0;
              full         <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state        <= S_IDLE;
          bus.wr_ready <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
